// File: rtl/gem_cluster_lct_window_match_if.sv
// Bus between the cluster translator / LCT builder and the window matcher.
interface gem_cluster_lct_window_match_if #(
   parameter int unsigned WIREBITS  = 7,
   parameter int unsigned STRIPBITS = 8
);
   logic                 frame_start;
   logic                 clst_vpf;
   logic [WIREBITS-1:0]  clst_wire_lo;
   logic [WIREBITS-1:0]  clst_wire_hi;
   logic [STRIPBITS-1:0] clst_hs_lo;
   logic [STRIPBITS-1:0] clst_hs_hi;
   logic                 clst_me1a;
   logic [2:0]           clst_roll;
   logic [7:0]           clst_pad;
   logic                 lct_valid;
   logic [WIREBITS-1:0]  lct_key_wg;
   logic [STRIPBITS-1:0] lct_key_hs;
   logic                 busy;
   logic                 match_done;
   logic                 match_found;
   logic [2:0]           match_index;
   logic [7:0]           match_pad;
   logic [2:0]           match_roll;
   logic [3:0]           match_count;
   logic                 lct_dropped;
   logic                 match_abort;
   logic                 overflow;

   modport master (
      output frame_start, clst_vpf, clst_wire_lo, clst_wire_hi, clst_hs_lo, clst_hs_hi,
             clst_me1a, clst_roll, clst_pad, lct_valid, lct_key_wg, lct_key_hs,
      input  busy, match_done, match_found, match_index, match_pad, match_roll,
             match_count, lct_dropped, match_abort, overflow
   );

   modport slave (
      input  frame_start, clst_vpf, clst_wire_lo, clst_wire_hi, clst_hs_lo, clst_hs_hi,
             clst_me1a, clst_roll, clst_pad, lct_valid, lct_key_wg, lct_key_hs,
      output busy, match_done, match_found, match_index, match_pad, match_roll,
             match_count, lct_dropped, match_abort, overflow
   );
endinterface

// File: rtl/gem_cluster_lct_window_match.sv
// Buffers translated GEM clusters for one BX frame and, on an LCT request, scans them one per
// clock for wire/halfstrip windows that contain the LCT key.
module gem_cluster_lct_window_match #(
   parameter int unsigned          MXCLST     = 8,
   parameter int unsigned          WIREBITS   = 7,
   parameter int unsigned          STRIPBITS  = 8,
   parameter logic [STRIPBITS-1:0] ME1A_MINHS = 8'd128
) (
   input logic                            clock,
   input logic                            reset,
   gem_cluster_lct_window_match_if.slave  bus
);
   localparam int unsigned PTRBITS = $clog2(MXCLST);
   localparam int unsigned CNTBITS = $clog2(MXCLST + 1);
   localparam logic [STRIPBITS-1:0] HS_INVALID = STRIPBITS'(224);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

   logic [WIREBITS-1:0]  ent_wire_lo [MXCLST];
   logic [WIREBITS-1:0]  ent_wire_hi [MXCLST];
   logic [STRIPBITS-1:0] ent_hs_lo   [MXCLST];
   logic [STRIPBITS-1:0] ent_hs_hi   [MXCLST];
   logic                 ent_me1a    [MXCLST];
   logic [2:0]           ent_roll    [MXCLST];
   logic [7:0]           ent_pad     [MXCLST];

   logic [PTRBITS-1:0]   wr_ptr_q, wr_ptr_d, wr_addr;
   logic [CNTBITS-1:0]   count_q, count_d;
   logic                 overflow_q, overflow_d, wr_en;

   state_t               state_q, state_d;
   logic [PTRBITS-1:0]   scan_idx_q, scan_idx_d;
   logic [CNTBITS-1:0]   scan_n_q, scan_n_d;
   logic [WIREBITS-1:0]  key_wg_q, key_wg_d;
   logic [STRIPBITS-1:0] key_hs_q, key_hs_d;
   logic                 found_q, found_d;
   logic [2:0]           index_q, index_d;
   logic [7:0]           pad_q, pad_d;
   logic [2:0]           roll_q, roll_d;
   logic [3:0]           mcount_q, mcount_d;
   logic                 hit;

   // Write pointer / fill count; frame_start clears before a same-cycle write lands.
   always_comb begin
      wr_addr    = bus.frame_start ? '0 : wr_ptr_q;
      wr_ptr_d   = wr_addr;
      count_d    = bus.frame_start ? '0 : count_q;
      overflow_d = bus.frame_start ? 1'b0 : overflow_q;
      wr_en      = 1'b0;
      if (bus.clst_vpf) begin
         if (count_d < CNTBITS'(MXCLST)) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_addr + 1'b1;
            count_d  = count_d + 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // Cluster buffer; contents are don't-care after reset, so no reset term.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         ent_wire_lo[wr_addr] <= bus.clst_wire_lo;
         ent_wire_hi[wr_addr] <= bus.clst_wire_hi;
         ent_hs_lo[wr_addr]   <= bus.clst_hs_lo;
         ent_hs_hi[wr_addr]   <= bus.clst_hs_hi;
         ent_me1a[wr_addr]    <= bus.clst_me1a;
         ent_roll[wr_addr]    <= bus.clst_roll;
         ent_pad[wr_addr]     <= bus.clst_pad;
      end
   end

   // Window test of the entry under the scan pointer; the invalid-region code never matches.
   always_comb begin
      hit = (key_wg_q >= ent_wire_lo[scan_idx_q]) && (key_wg_q <= ent_wire_hi[scan_idx_q])
         && (key_hs_q >= ent_hs_lo[scan_idx_q]) && (key_hs_q <= ent_hs_hi[scan_idx_q])
         && (ent_me1a[scan_idx_q] == (key_hs_q >= ME1A_MINHS))
         && (ent_hs_lo[scan_idx_q] != HS_INVALID) && (ent_hs_hi[scan_idx_q] != HS_INVALID)
         && (key_hs_q != HS_INVALID);
   end

   // FSM next state and result datapath.
   always_comb begin
      state_d    = state_q;
      scan_idx_d = scan_idx_q;
      scan_n_d   = scan_n_q;
      key_wg_d   = key_wg_q;
      key_hs_d   = key_hs_q;
      found_d    = found_q;
      index_d    = index_q;
      pad_d      = pad_q;
      roll_d     = roll_q;
      mcount_d   = mcount_q;
      unique case (state_q)
         StIdle: begin
            if (bus.lct_valid) begin
               key_wg_d   = bus.lct_key_wg;
               key_hs_d   = bus.lct_key_hs;
               scan_n_d   = count_q;
               scan_idx_d = '0;
               found_d    = 1'b0;
               index_d    = '0;
               pad_d      = '0;
               roll_d     = '0;
               mcount_d   = '0;
               state_d    = (count_q == '0) ? StDone : StScan;
            end
         end
         StScan: begin
            if (bus.frame_start) begin
               state_d = StIdle;
            end else begin
               if (hit) begin
                  if (!found_q) begin
                     found_d = 1'b1;
                     index_d = 3'(scan_idx_q);
                     pad_d   = ent_pad[scan_idx_q];
                     roll_d  = ent_roll[scan_idx_q];
                  end
                  if (mcount_q != 4'hF) mcount_d = mcount_q + 4'd1;
               end
               scan_idx_d = scan_idx_q + 1'b1;
               if (CNTBITS'(scan_idx_q) + CNTBITS'(1) == scan_n_q) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= StIdle;
         scan_idx_q <= '0;
         scan_n_q   <= '0;
         key_wg_q   <= '0;
         key_hs_q   <= '0;
         found_q    <= 1'b0;
         index_q    <= '0;
         pad_q      <= '0;
         roll_q     <= '0;
         mcount_q   <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         scan_idx_q <= scan_idx_d;
         scan_n_q   <= scan_n_d;
         key_wg_q   <= key_wg_d;
         key_hs_q   <= key_hs_d;
         found_q    <= found_d;
         index_q    <= index_d;
         pad_q      <= pad_d;
         roll_q     <= roll_d;
         mcount_q   <= mcount_d;
      end
   end

   assign bus.busy        = (state_q != StIdle);
   assign bus.match_done  = (state_q == StDone);
   assign bus.match_found = found_q;
   assign bus.match_index = index_q;
   assign bus.match_pad   = pad_q;
   assign bus.match_roll  = roll_q;
   assign bus.match_count = mcount_q;
   assign bus.lct_dropped = bus.lct_valid && (state_q != StIdle);
   assign bus.match_abort = bus.frame_start && (state_q == StScan);
   assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_gem_cluster_lct_window_match.sv
// Directed bench for the GEM cluster / LCT window matcher.
module tb_gem_cluster_lct_window_match;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   lat;
   int   ndone;

   gem_cluster_lct_window_match_if #(.WIREBITS(7), .STRIPBITS(8)) bus ();

   gem_cluster_lct_window_match dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle (negedge) and drop all strobes.
   task automatic step();
      @(negedge clock);
      bus.clst_vpf    = 1'b0;
      bus.lct_valid   = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   task automatic clst(input int wlo, input int whi, input int hlo, input int hhi,
                       input bit me1a, input int roll, input int pad);
      step();
      bus.clst_vpf     = 1'b1;
      bus.clst_wire_lo = 7'(wlo);
      bus.clst_wire_hi = 7'(whi);
      bus.clst_hs_lo   = 8'(hlo);
      bus.clst_hs_hi   = 8'(hhi);
      bus.clst_me1a    = me1a;
      bus.clst_roll    = 3'(roll);
      bus.clst_pad     = 8'(pad);
   endtask

   task automatic frame();
      step();
      bus.frame_start = 1'b1;
   endtask

   task automatic lct(input int wg, input int hs);
      step();
      bus.lct_valid  = 1'b1;
      bus.lct_key_wg = 7'(wg);
      bus.lct_key_hs = 8'(hs);
   endtask

   // Cycles from the last driven cycle to match_done; -1 if the budget runs out.
   task automatic run_until_done(output int l);
      l = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         #1;
         if (bus.match_done === 1'b1) begin
            l = k;
            break;
         end
         chk("busy_while_scan", 32'(bus.busy), 1);
      end
   endtask

   task automatic chk_result(input string tag, input int found, input int idx, input int cnt);
      chk({tag, "_found"}, 32'(bus.match_found), 32'(found));
      chk({tag, "_index"}, 32'(bus.match_index), 32'(idx));
      chk({tag, "_count"}, 32'(bus.match_count), 32'(cnt));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.match_done), 0);
      chk({tag, "_found"}, 32'(bus.match_found), 0);
      chk({tag, "_index"}, 32'(bus.match_index), 0);
      chk({tag, "_pad"}, 32'(bus.match_pad), 0);
      chk({tag, "_roll"}, 32'(bus.match_roll), 0);
      chk({tag, "_count"}, 32'(bus.match_count), 0);
      chk({tag, "_dropped"}, 32'(bus.lct_dropped), 0);
      chk({tag, "_abort"}, 32'(bus.match_abort), 0);
      chk({tag, "_overflow"}, 32'(bus.overflow), 0);
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.clst_vpf = 1'b0;
      bus.clst_wire_lo = '0;
      bus.clst_wire_hi = '0;
      bus.clst_hs_lo = '0;
      bus.clst_hs_hi = '0;
      bus.clst_me1a = 1'b0;
      bus.clst_roll = '0;
      bus.clst_pad = '0;
      bus.lct_valid = 1'b0;
      bus.lct_key_wg = '0;
      bus.lct_key_hs = '0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk_all_zero("reset");
      step();
      reset = 1'b0;

      // Three ME1b clusters, key (12,46) hits entries 0 and 2
      clst(10, 14, 40, 50, 1'b0, 1, 8'h11);
      clst(20, 24, 60, 70, 1'b0, 2, 8'h22);
      clst(10, 14, 44, 48, 1'b0, 3, 8'h33);
      lct(12, 46);
      #1;
      chk("lct_accept_dropped", 32'(bus.lct_dropped), 0);
      chk("lct_accept_busy", 32'(bus.busy), 0);
      run_until_done(lat);
      chk("three_latency", 32'(lat), 4);
      chk_result("three", 1, 0, 2);
      chk("three_pad", 32'(bus.match_pad), 32'h11);
      chk("three_roll", 32'(bus.match_roll), 1);
      step();
      #1;
      chk("done_one_cycle", 32'(bus.match_done), 0);
      chk("idle_after_done", 32'(bus.busy), 0);
      chk("result_holds", 32'(bus.match_count), 2);

      // Empty buffer
      frame();
      lct(12, 46);
      run_until_done(lat);
      chk("empty_latency", 32'(lat), 1);
      chk_result("empty", 0, 0, 0);

      // Overflow: nine writes, eight stored
      frame();
      for (int i = 0; i < 9; i++) begin
         clst(50, 60, 100, 110, 1'b0, 4, i);
         #1;
         chk("overflow_before_full", 32'(bus.overflow), 0);
      end
      step();
      #1;
      chk("overflow_set", 32'(bus.overflow), 1);
      lct(55, 105);
      run_until_done(lat);
      chk("full_latency", 32'(lat), 9);
      chk_result("full", 1, 0, 8);
      frame();
      step();
      #1;
      chk("overflow_cleared", 32'(bus.overflow), 0);
      lct(55, 105);
      run_until_done(lat);
      chk("cleared_latency", 32'(lat), 1);
      chk_result("cleared", 0, 0, 0);

      // frame_start with a write in the same cycle leaves one entry (ME1a, roll 7)
      clst(0, 5, 0, 200, 1'b0, 1, 1);
      clst(0, 5, 0, 200, 1'b0, 1, 2);
      clst(0, 5, 130, 140, 1'b1, 7, 8'h55);
      bus.frame_start = 1'b1;
      lct(3, 135);
      run_until_done(lat);
      chk("fs_write_latency", 32'(lat), 2);
      chk_result("me1a_hit", 1, 0, 1);
      chk("me1a_roll", 32'(bus.match_roll), 7);
      chk("me1a_pad", 32'(bus.match_pad), 32'h55);
      lct(3, 100);
      run_until_done(lat);
      chk_result("me1a_miss", 0, 0, 0);
      lct(5, 140);
      run_until_done(lat);
      chk_result("edges_inclusive", 1, 0, 1);
      lct(6, 135);
      run_until_done(lat);
      chk_result("wire_above_hi", 0, 0, 0);

      // ME1b entry overlapping the ME1a boundary only matches keys below 128
      clst(0, 5, 120, 135, 1'b0, 2, 8'h66);
      lct(3, 130);
      run_until_done(lat);
      chk_result("me1a_side", 1, 0, 1);
      lct(3, 125);
      run_until_done(lat);
      chk_result("me1b_side", 1, 1, 1);
      chk("me1b_side_pad", 32'(bus.match_pad), 32'h66);
      chk("me1b_side_roll", 32'(bus.match_roll), 2);

      // Repeated lct_valid during a 4-entry scan is dropped; one match_done at T+5
      frame();
      for (int i = 0; i < 4; i++) clst(10, 14, 40, 50, 1'b0, 0, i);
      lct(12, 46);
      lct(12, 46);
      #1;
      chk("dropped_pulse", 32'(bus.lct_dropped), 1);
      run_until_done(lat);
      chk("drop_latency", 32'(lat), 4);
      chk_result("drop", 1, 0, 4);
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         #1;
         if (bus.match_done === 1'b1) ndone++;
      end
      chk("drop_single_done", 32'(ndone), 0);

      // frame_start at T+2 aborts the scan
      lct(12, 46);
      step();
      frame();
      #1;
      chk("abort_pulse", 32'(bus.match_abort), 1);
      step();
      #1;
      chk("abort_idle", 32'(bus.busy), 0);
      chk("abort_pulse_gone", 32'(bus.match_abort), 0);
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.match_done === 1'b1) ndone++;
         step();
         #1;
      end
      chk("abort_no_done", 32'(ndone), 0);

      // frame_start in the DONE cycle still lets match_done through
      lct(12, 46);
      frame();
      #1;
      chk("fs_in_done_done", 32'(bus.match_done), 1);
      chk("fs_in_done_no_abort", 32'(bus.match_abort), 0);

      // Reset in the middle of a scan
      for (int i = 0; i < 4; i++) clst(10, 14, 40, 50, 1'b0, 0, i);
      lct(12, 46);
      repeat ($urandom_range(1, 3)) step();
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("mid_reset");
      step();
      reset = 1'b0;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         #1;
         if (bus.match_done === 1'b1) ndone++;
      end
      chk("mid_reset_no_done", 32'(ndone), 0);
      chk("mid_reset_idle", 32'(bus.busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
